chip_stream_feeder: RTL
=======================

Name: chip_stream_feeder

Overview:
- Drives the edge-detection core's input side: reads a 20x20 image of 5-bit pixels from a word-wide image ROM and streams it as 5 pixels per cycle with `load_end` on the final beat.
- Then collects the serial `edge_out` result bits, qualified by `readable`, into a result RAM and counts the edge pixels.
- Sits between the test/host memory and the edge core; it is the transmitter for the core's load interface and the receiver for its result interface.

Parameters:
- IMG_DIM, 20, image side length in pixels
- BIT_LENGTH, 5, bits per pixel
- PIX_PER_BEAT, 5, pixels sent per cycle; IMG_DIM*IMG_DIM must be divisible by it
- RES_DIM, 18, result side length (IMG_DIM-2)
- TIMEOUT_CYCLES, 4096, watchdog limit; used only with the optional feature

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle request to begin a frame; sampled in IDLE only
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse when the frame completes
- rom_rd  out  1  ROM read enable
- rom_addr  out  7  ROM word address, 0..79
- rom_data  in  25  one beat: pixel0 in bits [4:0] through pixel4 in bits [24:20]; valid the cycle after rom_rd
- pixel_out0..pixel_out4  out  5 each  pixels to the core, registered
- load_end  out  1  high during the last beat only
- edge_in  in  1  result bit from the core
- readable  in  1  edge_in valid this cycle
- res_we  out  1  result RAM write enable
- res_addr  out  9  result index, 0..323
- res_data  out  1  result bit
- edge_count  out  9  number of 1 bits collected in the current or last frame
- timeout  out  1  sticky watchdog flag

Behaviour:
- Reset: all outputs 0 and the FSM in IDLE. Reset asserted mid-frame aborts the frame immediately, with no done pulse; edge_count is cleared.
- BEATS = IMG_DIM*IMG_DIM/PIX_PER_BEAT = 80.
- NRES = RES_DIM*RES_DIM = 324.

FSM states: IDLE, PRIME, STREAM, COLLECT, FINISH.
- IDLE:
  - start=1 goes to PRIME; busy rises the next cycle.
  - edge_count clears on acceptance.
- PRIME (1 cycle): rom_rd=1, rom_addr=0.
- STREAM (exactly 80 cycles, no bubbles):
  - In stream cycle k (0..79), pixel_out0..4 hold beat k, registered from rom_data.
  - The ROM read for beat k+1 is issued in the same cycle k, with rom_addr=k+1 for k<79; rom_rd=0 in cycle 79.
  - load_end=1 only in cycle k=79.
  - Beat k holds image pixels 5k..5k+4, row-major, with pixel_out0 = the lowest index.
  - readable is ignored in STREAM.
- COLLECT:
  - pixel_out and load_end return to 0.
  - Each cycle with readable=1: res_we=1, res_data=edge_in, res_addr=result index r. Then r increments, and edge_count increments if edge_in=1. These are same-cycle combinational outputs.
  - After sample r=323 is written, go to FINISH.
  - Cycles with readable=0 write nothing.
- FINISH (1 cycle): done=1, busy drops to 0 in the same cycle, then IDLE.
- Latency: first beat appears 2 cycles after the start cycle; the load phase is 80 cycles.
- start while busy is ignored.
- start coincident with FINISH is ignored; a new start is needed in IDLE.
- readable in IDLE/PRIME/FINISH is ignored; no writes occur.
- edge_count saturates at 324 by construction and holds its value until the next accepted start.

Optional Feature:
- Macro STREAM_TIMEOUT_EN.
- Defined:
  - A counter runs in COLLECT and clears each time readable=1.
  - If it reaches TIMEOUT_CYCLES, set timeout=1 (sticky until reset or the next accepted start) and go to FINISH; done still pulses, and the partial edge_count is kept.
- Undefined: no counter; timeout is tied to 0 and COLLECT waits indefinitely.

Test Plan:
- ROM word k = {5{k[4:0]}}, start pulsed once -> pixel_out0..4 = 0,0,0,0,0 in stream cycle 0; all = 79 mod 32 = 15 at k=79; load_end high only at k=79; rom_addr 0..79 contiguous.
- readable held high for 324 cycles with edge_in alternating 1,0,... -> res_addr 0..323, res_we count 324, edge_count=162, done one pulse, busy low after.
- readable toggling 1-cycle-on/2-off, edge_in=1 always -> exactly 324 writes, edge_count=324, no write on off cycles.
- start pulsed again at stream cycle 40, and readable=1 during STREAM -> no restart, no result writes before COLLECT.
- reset asserted at result index 100 -> all outputs 0 in the same cycle, IDLE; a following start runs a full clean frame with edge_count starting from 0.
- With STREAM_TIMEOUT_EN and TIMEOUT_CYCLES=16: 10 samples then readable=0 -> timeout=1, done pulse 16 cycles after the last sample, edge_count equals the 1s among those 10.

Source files
------------

// File: rtl/chip_stream_feeder.sv
// Feeds a 20x20 image to the edge core in 5-pixel beats, then gathers its result bits.
// Optional STREAM_TIMEOUT_EN adds a watchdog that ends a stalled collection.
module chip_stream_feeder #(
    parameter int IMG_DIM        = 20,
    parameter int BIT_LENGTH     = 5,
    parameter int PIX_PER_BEAT   = 5,
    parameter int RES_DIM        = 18,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic                               rom_rd,
    output logic [6:0]                         rom_addr,
    input  logic [PIX_PER_BEAT*BIT_LENGTH-1:0] rom_data,
    output logic [BIT_LENGTH-1:0]              pixel_out0,
    output logic [BIT_LENGTH-1:0]              pixel_out1,
    output logic [BIT_LENGTH-1:0]              pixel_out2,
    output logic [BIT_LENGTH-1:0]              pixel_out3,
    output logic [BIT_LENGTH-1:0]              pixel_out4,
    output logic                               load_end,
    input  logic                               edge_in,
    input  logic                               readable,
    output logic                               res_we,
    output logic [8:0]                         res_addr,
    output logic                               res_data,
    output logic [8:0]                         edge_count,
    output logic                               timeout
);

    localparam int BEATS = IMG_DIM * IMG_DIM / PIX_PER_BEAT;
    localparam int NRES  = RES_DIM * RES_DIM;
    localparam logic [6:0] LAST_B = 7'(BEATS - 1);
    localparam logic [8:0] LAST_R = 9'(NRES - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] PRIME   = 3'd1;
    localparam logic [2:0] STREAM  = 3'd2;
    localparam logic [2:0] COLLECT = 3'd3;
    localparam logic [2:0] FINISH  = 3'd4;

    logic [2:0] state;
    logic [6:0] beat;
    logic [8:0] ridx;
    logic       wd_hit;
    logic       in_stream;
    logic       in_collect;

    assign in_stream  = (state == STREAM);
    assign in_collect = (state == COLLECT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            beat       <= '0;
            ridx       <= '0;
            edge_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= PRIME;
                        beat       <= '0;
                        ridx       <= '0;
                        edge_count <= '0;
                    end
                end
                PRIME: begin
                    state <= STREAM;
                    beat  <= '0;
                end
                STREAM: begin
                    if (beat == LAST_B)
                        state <= COLLECT;
                    else
                        beat <= beat + 7'd1;
                end
                COLLECT: begin
                    if (readable) begin
                        ridx       <= ridx + 9'd1;
                        edge_count <= edge_count + {8'd0, edge_in};
                        if (ridx == LAST_R)
                            state <= FINISH;
                    end else if (wd_hit) begin
                        state <= FINISH;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STREAM_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDW-1:0] wd;
    logic           timeout_q;

    // wd holds the number of cycles since the last sample, counting that sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd        <= WDW'(1);
            timeout_q <= 1'b0;
        end else begin
            if (state == IDLE && start)
                timeout_q <= 1'b0;
            if (wd_hit)
                timeout_q <= 1'b1;
            if (in_collect && !readable)
                wd <= wd + WDW'(1);
            else
                wd <= WDW'(1);
        end
    end

    assign wd_hit  = in_collect && !readable && (wd == WDW'(TIMEOUT_CYCLES - 1));
    assign timeout = timeout_q;
`else
    assign wd_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    assign busy = (state == PRIME) || in_stream || in_collect;
    assign done = (state == FINISH);

    assign rom_rd   = (state == PRIME) || (in_stream && beat != LAST_B);
    assign rom_addr = (in_stream && beat != LAST_B) ? beat + 7'd1 : 7'd0;
    assign load_end = in_stream && (beat == LAST_B);

    // The ROM's output register is the pixel register; it is only gated here
    assign pixel_out0 = in_stream ? rom_data[0*BIT_LENGTH +: BIT_LENGTH] : '0;
    assign pixel_out1 = in_stream ? rom_data[1*BIT_LENGTH +: BIT_LENGTH] : '0;
    assign pixel_out2 = in_stream ? rom_data[2*BIT_LENGTH +: BIT_LENGTH] : '0;
    assign pixel_out3 = in_stream ? rom_data[3*BIT_LENGTH +: BIT_LENGTH] : '0;
    assign pixel_out4 = in_stream ? rom_data[4*BIT_LENGTH +: BIT_LENGTH] : '0;

    assign res_we   = in_collect && readable;
    assign res_addr = res_we ? ridx : 9'd0;
    assign res_data = res_we && edge_in;

endmodule
